router_fifo: RTL and testbench



---
 rtl/router_fifo.sv | 122 ++++++++++++
 tb/tb_router_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// router_fifo: per-destination output FIFO of the 1x3 router.
//
// Buffers header, payload and parity bytes. Each entry carries a header tag
// bit, so the read side can load a packet byte counter from the header's
// length field and fall back to the idle output once a packet has drained.
//
// Ports:
//   clk         single clock, rising edge
//   resetn      asynchronous active-low reset
//   soft_reset  synchronous flush (pointers, packet counter, output)
//   write_enb   write strobe (one bit of the synchroniser one-hot vector)
//   lfd_state   marks the byte on data_in as a packet header
//   data_in     byte to store
//   read_enb    read strobe from the destination client
//   data_out    registered read data (idle value when no packet in flight)
//   full        FIFO holds DEPTH entries
//   empty       FIFO holds no entries
//
// Build option: ROUTER_FIFO_TRISTATE_EN makes the idle/reset value of
// data_out all-Z so the port can share an external bus; otherwise the idle
// value is all-zero and no Z is driven.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [WIDTH-1:0] IDLE_VAL = {WIDTH{1'bz}};
`else
  localparam logic [WIDTH-1:0] IDLE_VAL = {WIDTH{1'b0}};
`endif

  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [WIDTH-2:0] CNT_ONE = {{(WIDTH-2){1'b0}}, 1'b1};

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-2:0] pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             oe_q, oe_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH:0]   rd_entry;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Both strobes are judged against the flags at the start of the cycle.
  assign wr_acc   = write_enb && !full;
  assign rd_acc   = read_enb && !empty;
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    data_d    = data_q;
    oe_d      = oe_q;
    if (soft_reset) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      pkt_cnt_d = '0;
      data_d    = '0;
      oe_d      = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        data_d   = rd_entry[WIDTH-1:0];
        oe_d     = 1'b1;
        // Header length field counts payload bytes; +1 covers parity.
        if (rd_entry[WIDTH])
          pkt_cnt_d = {1'b0, rd_entry[WIDTH-1:2]} + CNT_ONE;
        else if (pkt_cnt_q != '0)
          pkt_cnt_d = pkt_cnt_q - CNT_ONE;
      end else if (pkt_cnt_q == '0) begin
        data_d = '0;
        oe_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      data_q    <= '0;
      oe_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
    end
  end

  // Storage is never cleared; a flush only moves the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc && !soft_reset)
      mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
  end

  // oe_q low selects the idle value (all-Z on a shared bus, else zero).
  assign data_out = oe_q ? data_q : IDLE_VAL;

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [7:0] IDLE = 8'hzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       read_enb = 1'b0;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_vec = 0;
  int n_err = 0;

  router_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic lfd, input logic [7:0] d);
    write_enb = 1'b1;
    lfd_state = lfd;
    data_in   = d;
    tick();
    write_enb = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic rd();
    read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
  endtask

  logic [7:0] pkt_data [5] = '{8'h0C, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [6:0] pkt_cnt_exp [5] = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0};

  initial begin
    // Reset state
    #12;
    chk("rst_empty", 16'(empty), 16'd1);
    chk("rst_full", 16'(full), 16'd0);
    chk("rst_dout", 16'(data_out), 16'(IDLE));
    chk("rst_pkt", 16'(dut.pkt_cnt_q), 16'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Header 0C (length 3) plus four bytes, read back
    wr(1'b1, pkt_data[0]);
    chk("t1_empty_after_wr", 16'(empty), 16'd0);
    for (int i = 1; i < 5; i++) wr(1'b0, pkt_data[i]);
    for (int i = 0; i < 5; i++) begin
      rd();
      chk($sformatf("t1_dout%0d", i), 16'(data_out), 16'(pkt_data[i]));
      chk($sformatf("t1_pkt%0d", i), 16'(dut.pkt_cnt_q), 16'(pkt_cnt_exp[i]));
    end
    tick();
    chk("t1_dout_idle", 16'(data_out), 16'(IDLE));
    chk("t1_empty", 16'(empty), 16'd1);

    // Fill to 16, drop the 17th, drain
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_full_before%0d", i), 16'(full), 16'd0);
      wr(1'b0, 8'h10 + 8'(i));
    end
    chk("t2_full", 16'(full), 16'd1);
    wr(1'b0, 8'hFF);
    chk("t2_full_after_drop", 16'(full), 16'd1);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk($sformatf("t2_dout%0d", i), 16'(data_out), 16'(8'h10 + 8'(i)));
      chk($sformatf("t2_full_drain%0d", i), 16'(full), 16'd0);
    end
    chk("t2_empty", 16'(empty), 16'd1);
    rd();
    chk("t2_rd_empty_dout", 16'(data_out), 16'(IDLE));
    chk("t2_rd_empty_still", 16'(empty), 16'd1);

    // Simultaneous read and write while full, then again at 15 entries
    for (int i = 0; i < 16; i++) wr(1'b0, 8'h40 + 8'(i));
    chk("t3_full", 16'(full), 16'd1);
    read_enb = 1'b1; write_enb = 1'b1; data_in = 8'hEE;
    tick();
    chk("t3_rw_full_dout", 16'(data_out), 16'h40);
    chk("t3_rw_full_flag", 16'(full), 16'd0);
    data_in = 8'hEF;
    tick();
    read_enb = 1'b0; write_enb = 1'b0;
    chk("t3_rw_dout", 16'(data_out), 16'h41);
    chk("t3_rw_flag", 16'(full), 16'd0);
    for (int i = 0; i < 14; i++) begin
      rd();
      chk($sformatf("t3_dout%0d", i), 16'(data_out), 16'(8'h42 + 8'(i)));
    end
    rd();
    chk("t3_dout_last", 16'(data_out), 16'hEF);
    chk("t3_empty", 16'(empty), 16'd1);
    tick();

    // Soft reset mid-packet with a concurrent write
    wr(1'b1, 8'h08);
    wr(1'b0, 8'h02);
    wr(1'b0, 8'h03);
    rd();
    chk("t4_dout_hdr", 16'(data_out), 16'h08);
    chk("t4_pkt", 16'(dut.pkt_cnt_q), 16'd3);
    soft_reset = 1'b1; write_enb = 1'b1; data_in = 8'h55;
    tick();
    soft_reset = 1'b0; write_enb = 1'b0;
    chk("t4_empty", 16'(empty), 16'd1);
    chk("t4_full", 16'(full), 16'd0);
    chk("t4_dout_idle", 16'(data_out), 16'(IDLE));
    chk("t4_pkt_clr", 16'(dut.pkt_cnt_q), 16'd0);
    rd();
    chk("t4_rd_empty_dout", 16'(data_out), 16'(IDLE));
    chk("t4_rd_empty", 16'(empty), 16'd1);
    wr(1'b0, 8'h66);
    rd();
    chk("t4_after_flush", 16'(data_out), 16'h66);
    chk("t4_empty_end", 16'(empty), 16'd1);

    // 40 single-byte packets: pointers wrap several times
    for (int i = 0; i < 40; i++) begin
      wr(1'b1, 8'h00);
      wr(1'b0, 8'(i * 3 + 1));
      chk($sformatf("t5_nempty%0d", i), 16'(empty), 16'd0);
      rd();
      chk($sformatf("t5_hdr%0d", i), 16'(data_out), 16'h00);
      chk($sformatf("t5_pkt%0d", i), 16'(dut.pkt_cnt_q), 16'd1);
      rd();
      chk($sformatf("t5_par%0d", i), 16'(data_out), 16'(8'(i * 3 + 1)));
      chk($sformatf("t5_empty%0d", i), 16'(empty), 16'd1);
      chk($sformatf("t5_full%0d", i), 16'(full), 16'd0);
    end
    tick();
    chk("t5_idle", 16'(data_out), 16'(IDLE));

    // Asynchronous reset between edges mid-packet
    wr(1'b1, 8'h0C);
    wr(1'b0, 8'h91);
    wr(1'b0, 8'h92);
    rd();
    chk("t6_dout_hdr", 16'(data_out), 16'h0C);
    #3;
    resetn = 1'b0;
    #1;
    chk("t6_empty", 16'(empty), 16'd1);
    chk("t6_full", 16'(full), 16'd0);
    chk("t6_dout", 16'(data_out), 16'(IDLE));
    chk("t6_pkt", 16'(dut.pkt_cnt_q), 16'd0);
    read_enb = 1'b1; write_enb = 1'b1; data_in = 8'hAA;
    tick();
    tick();
    read_enb = 1'b0; write_enb = 1'b0;
    chk("t6_hold_empty", 16'(empty), 16'd1);
    chk("t6_hold_dout", 16'(data_out), 16'(IDLE));
    @(negedge clk);
    resetn = 1'b1;
    tick();
    wr(1'b0, 8'h77);
    rd();
    chk("t6_after_rst", 16'(data_out), 16'h77);
    chk("t6_empty_end", 16'(empty), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
